unpacker32to8: RTL and testbench
================================

UNPACKER32TO8 -- requirements
Module: unpacker32to8

Interface
REQ-001 Parameter DATA_LEN, default 32, SHALL set the FIFO word width.
REQ-002 Parameter LVDS_LEN, default 8, SHALL set the output byte width; DATA_LEN = 4*LVDS_LEN is the only supported configuration.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 fifo_empty  input  1  SHALL indicate that the upstream FIFO holds no word.
REQ-006 fifo_rd_en  output  1  SHALL request one word from the FIFO.
REQ-007 fifo_data  input  DATA_LEN  SHALL carry the read word, valid exactly one cycle after fifo_rd_en is high.
REQ-008 flush  input  1  SHALL be a synchronous discard of all held and in-flight words.
REQ-009 ready_in  input  1  SHALL indicate that downstream accepts a byte this cycle.
REQ-010 valid_out  output  1  SHALL indicate that data_out holds a valid byte.
REQ-011 data_out  output  LVDS_LEN  SHALL carry the current byte.

Function
REQ-012 Internal state SHALL be: shift word + sh_valid + byte_cnt[1:0]; prefetch word + pf_valid; rd_pend (read issued last cycle).
REQ-013 fifo_rd_en SHALL equal !fifo_empty && !rd_pend && !pf_valid && !flush, decoded from registers and inputs only.
REQ-014 rd_pend SHALL register fifo_rd_en every cycle.
REQ-015 valid_out SHALL equal sh_valid; data_out SHALL equal shift word bits [8*byte_cnt+7 : 8*byte_cnt], i.e. LSB byte first.
REQ-016 Accept = valid_out && ready_in; on accept with byte_cnt < 3, byte_cnt SHALL increment.
REQ-017 On accept with byte_cnt = 3, byte_cnt SHALL become 0 and the shift word SHALL reload from: prefetch if pf_valid (pf_valid cleared), else fifo_data if rd_pend, else sh_valid SHALL clear.
REQ-018 When rd_pend and the shift stage is empty, fifo_data SHALL load the shift word with sh_valid = 1, byte_cnt = 0.
REQ-019 When rd_pend and the shift stage is occupied and not releasing its last byte this cycle, fifo_data SHALL load the prefetch word with pf_valid = 1.
REQ-020 If rd_pend coincides with a last-byte accept while pf_valid = 1, the prefetch word SHALL move to the shift stage and fifo_data SHALL load the prefetch stage; no word SHALL ever be dropped.
REQ-021 While ready_in is low, data_out, byte_cnt and both word stages SHALL hold.
REQ-022 Latency: from an idle block with fifo_empty falling at cycle 0, fifo_rd_en SHALL be high at cycle 0 and valid_out high at cycle 2.
REQ-023 With ready_in held high and the FIFO non-empty, valid_out SHALL remain high with no gap between words (1 byte/clk).
REQ-024 flush SHALL clear sh_valid, pf_valid, rd_pend and byte_cnt next cycle; a word returning from a read issued the cycle before flush SHALL be discarded.
REQ-025 fifo_empty asserting mid-word SHALL not affect bytes already held.

Reset
REQ-026 While rst_n is low: valid_out = 0, data_out = 0, fifo_rd_en = 0, byte_cnt = 0, sh_valid = pf_valid = rd_pend = 0, both word registers = 0.
REQ-027 Reset asserted mid-word SHALL discard all held bytes; no partial word SHALL resume after release.
REQ-028 The first fifo_rd_en after reset release SHALL occur no earlier than the first clk edge with rst_n high.

Structure
REQ-029 A shared package SHALL hold DATA_LEN, LVDS_LEN and the bytes-per-word constant (4), shared with the 8-to-32 packer.
REQ-030 The block SHALL be flat; no sub-module is required.

Verification
REQ-031 One word 0xDDCCBBAA, ready_in = 1 -> fifo_rd_en at cycle 0; data_out AA, BB, CC, DD at cycles 2-5; valid_out low at cycle 6.
REQ-032 Three words 0x03020100, 0x07060504, 0x0B0A0908 back-to-back, ready_in = 1 -> bytes 00..0B on 12 consecutive cycles with no valid_out gap.
REQ-033 Word 0x44332211, ready_in low during cycles 3-5 -> data_out holds 22 for cycles 3-5; then 33, 44; total 4 accepts.
REQ-034 Two words queued, ready_in low until both stages are full -> fifo_rd_en stays low; after release all 8 bytes arrive in order.
REQ-035 flush asserted the cycle after fifo_rd_en, with byte_cnt = 2 -> valid_out low next cycle; returning word ignored; next FIFO word starts at byte 0.
REQ-036 rst_n pulsed low at byte_cnt = 1 -> all outputs 0 during reset; after release the next FIFO word is emitted from its byte 0.

Source files
------------

// File: rtl/unpacker32to8_pkg.sv
// Shared width constants for the 32-to-8 unpacker and its 8-to-32 packer sibling.
package unpacker32to8_pkg;

    localparam int unsigned DATA_LEN       = 32;
    localparam int unsigned LVDS_LEN       = 8;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned BYTE_CNT_W     = $clog2(BYTES_PER_WORD);

    localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = BYTE_CNT_W'(BYTES_PER_WORD - 1);

endpackage

// File: rtl/unpacker32to8.sv
// Splits FIFO words into LSB-first bytes using a shift stage and a one-word prefetch stage,
// sustaining one byte per clock with a single-cycle FIFO read latency.
module unpacker32to8
    import unpacker32to8_pkg::*;
#(
    parameter int unsigned DATA_LEN = unpacker32to8_pkg::DATA_LEN,
    parameter int unsigned LVDS_LEN = unpacker32to8_pkg::LVDS_LEN
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                fifo_empty,
    output logic                fifo_rd_en,
    input  logic [DATA_LEN-1:0] fifo_data,
    input  logic                flush,
    input  logic                ready_in,
    output logic                valid_out,
    output logic [LVDS_LEN-1:0] data_out
);

    localparam int unsigned CNT_W = BYTE_CNT_W;

    logic [DATA_LEN-1:0] sh_word_q;
    logic [DATA_LEN-1:0] sh_word_d;
    logic                sh_valid_q;
    logic                sh_valid_d;
    logic [CNT_W-1:0]    byte_cnt_q;
    logic [CNT_W-1:0]    byte_cnt_d;
    logic [DATA_LEN-1:0] pf_word_q;
    logic [DATA_LEN-1:0] pf_word_d;
    logic                pf_valid_q;
    logic                pf_valid_d;
    logic                rd_pend_q;
    logic                run_q;
    logic                accept;
    logic                last_accept;

    // run_q keeps reads off until the first clock edge after reset release
    assign fifo_rd_en  = run_q && !fifo_empty && !rd_pend_q && !pf_valid_q && !flush;
    assign accept      = sh_valid_q && ready_in;
    assign last_accept = accept && (byte_cnt_q == LAST_BYTE);
    assign valid_out   = sh_valid_q;

    always_comb begin
        data_out = '0;
        for (int unsigned i = 0; i < BYTES_PER_WORD; i++) begin
            if (byte_cnt_q == CNT_W'(i)) begin
                data_out = sh_word_q[i*LVDS_LEN +: LVDS_LEN];
            end
        end
    end

    // Word-stage next state; a returning read word always lands in a free stage
    always_comb begin
        sh_word_d  = sh_word_q;
        sh_valid_d = sh_valid_q;
        byte_cnt_d = byte_cnt_q;
        pf_word_d  = pf_word_q;
        pf_valid_d = pf_valid_q;

        if (flush) begin
            sh_valid_d = 1'b0;
            pf_valid_d = 1'b0;
            byte_cnt_d = '0;
        end else if (last_accept) begin
            byte_cnt_d = '0;
            if (pf_valid_q) begin
                sh_word_d = pf_word_q;
                if (rd_pend_q) begin
                    pf_word_d = fifo_data;
                end else begin
                    pf_valid_d = 1'b0;
                end
            end else if (rd_pend_q) begin
                sh_word_d = fifo_data;
            end else begin
                sh_valid_d = 1'b0;
            end
        end else begin
            if (accept) begin
                byte_cnt_d = byte_cnt_q + CNT_W'(1);
            end
            if (rd_pend_q) begin
                if (!sh_valid_q) begin
                    sh_word_d  = fifo_data;
                    sh_valid_d = 1'b1;
                    byte_cnt_d = '0;
                end else begin
                    pf_word_d  = fifo_data;
                    pf_valid_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_word_q  <= '0;
            sh_valid_q <= 1'b0;
            byte_cnt_q <= '0;
            pf_word_q  <= '0;
            pf_valid_q <= 1'b0;
            rd_pend_q  <= 1'b0;
            run_q      <= 1'b0;
        end else begin
            sh_word_q  <= sh_word_d;
            sh_valid_q <= sh_valid_d;
            byte_cnt_q <= byte_cnt_d;
            pf_word_q  <= pf_word_d;
            pf_valid_q <= pf_valid_d;
            rd_pend_q  <= fifo_rd_en;
            run_q      <= 1'b1;
        end
    end

endmodule

// File: tb/tb_unpacker32to8.sv
// Scoreboard bench: a FIFO model queues expected bytes when a word is read; accepted bytes pop them.
module tb_unpacker32to8;
    import unpacker32to8_pkg::*;

    localparam time T_CLK = 10;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                fifo_empty = 1'b1;
    logic                fifo_rd_en;
    logic [DATA_LEN-1:0] fifo_data = '0;
    logic                flush = 1'b0;
    logic                ready_in = 1'b0;
    logic                valid_out;
    logic [LVDS_LEN-1:0] data_out;

    unpacker32to8 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en),
        .fifo_data (fifo_data),
        .flush     (flush),
        .ready_in  (ready_in),
        .valid_out (valid_out),
        .data_out  (data_out)
    );

    always #(T_CLK/2) clk = ~clk;

    logic [DATA_LEN-1:0] fifo_q[$];
    logic [LVDS_LEN-1:0] sb_q[$];
    logic [DATA_LEN-1:0] rd_word = '0;
    bit                  rd_prev = 1'b0;
    int                  n_vec = 0;
    int                  n_err = 0;
    int                  n_acc = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs at negedge, settle, then observe and model the FIFO
    task automatic tick(input bit rdy, input bit fl);
        @(negedge clk);
        ready_in   = rdy;
        flush      = fl;
        fifo_empty = (fifo_q.size() == 0);
        fifo_data  = rd_prev ? rd_word : DATA_LEN'($urandom);
        #1;
        if (valid_out && ready_in) begin
            n_acc++;
            if (sb_q.size() == 0) check_eq("spurious_byte", 32'(valid_out), 32'd0);
            else check_eq("byte", 32'(data_out), 32'(sb_q.pop_front()));
        end
        rd_prev = fifo_rd_en;
        if (fifo_rd_en) begin
            if (fifo_q.size() == 0) begin
                check_eq("rd_when_empty", 32'(fifo_rd_en), 32'd0);
                rd_prev = 1'b0;
            end else begin
                rd_word = fifo_q.pop_front();
                for (int b = 0; b < BYTES_PER_WORD; b++)
                    sb_q.push_back(rd_word[b*LVDS_LEN +: LVDS_LEN]);
            end
        end
        if (flush) sb_q.delete();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n      = 1'b0;
        ready_in   = 1'b0;
        flush      = 1'b0;
        fifo_empty = (fifo_q.size() == 0);
        #1;
        sb_q.delete();
        rd_prev = 1'b0;
        check_eq("rst_valid", 32'(valid_out), 32'd0);
        check_eq("rst_data", 32'(data_out), 32'd0);
        check_eq("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        @(negedge clk);
        #1;
        check_eq("rst_hold_valid", 32'(valid_out), 32'd0);
        rst_n = 1'b1;
        #1;
        check_eq("rel_rd_en", 32'(fifo_rd_en), 32'd0);
    endtask

    task automatic drain(input string tag, input int max_cyc);
        int k = 0;
        while ((sb_q.size() != 0 || fifo_q.size() != 0 || valid_out || rd_prev) && k < max_cyc) begin
            tick(1'b1, 1'b0);
            k++;
        end
        check_eq(tag, 32'(sb_q.size()), 32'd0);
    endtask

    task automatic wait_valid(input string tag, input int max_cyc);
        int k = 0;
        do begin
            tick(1'b1, 1'b0);
            k++;
        end while (!valid_out && k < max_cyc);
        check_eq(tag, 32'(valid_out), 32'd1);
    endtask

    initial begin
        logic [DATA_LEN-1:0] w;
        int acc0;

        apply_reset();

        // Single word: latency and LSB-first order
        w = 32'hDDCCBBAA;
        fifo_q.push_back(w);
        tick(1'b1, 1'b0);
        check_eq("t1_rd_c0", 32'(fifo_rd_en), 32'd1);
        check_eq("t1_valid_c0", 32'(valid_out), 32'd0);
        tick(1'b1, 1'b0);
        check_eq("t1_valid_c1", 32'(valid_out), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 1'b0);
            check_eq("t1_valid", 32'(valid_out), 32'd1);
            check_eq("t1_data", 32'(data_out), 32'(w[i*8 +: 8]));
        end
        tick(1'b1, 1'b0);
        check_eq("t1_valid_c6", 32'(valid_out), 32'd0);

        // Three back-to-back words: 12 gapless bytes
        fifo_q.push_back(32'h03020100);
        fifo_q.push_back(32'h07060504);
        fifo_q.push_back(32'h0B0A0908);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        for (int i = 0; i < 12; i++) begin
            tick(1'b1, 1'b0);
            check_eq("t2_nogap", 32'(valid_out), 32'd1);
            check_eq("t2_data", 32'(data_out), 32'(i));
        end
        tick(1'b1, 1'b0);
        check_eq("t2_valid_end", 32'(valid_out), 32'd0);

        // Backpressure mid-word
        acc0 = n_acc;
        fifo_q.push_back(32'h44332211);
        for (int c = 0; c < 10; c++) begin
            tick((c < 3 || c > 5) ? 1'b1 : 1'b0, 1'b0);
            if (c >= 3 && c <= 5) check_eq("t3_hold", 32'(data_out), 32'h22);
            if (c == 7) check_eq("t3_c7", 32'(data_out), 32'h33);
            if (c == 8) check_eq("t3_c8", 32'(data_out), 32'h44);
        end
        check_eq("t3_accepts", 32'(n_acc - acc0), 32'd4);

        // Both stages full: no further reads until downstream drains
        acc0 = n_acc;
        fifo_q.push_back(32'h13121110);
        fifo_q.push_back(32'h17161514);
        fifo_q.push_back(32'h1B1A1918);
        for (int c = 0; c < 10; c++) begin
            tick(1'b0, 1'b0);
            if (c == 0 || c == 2) check_eq("t4_rd_issue", 32'(fifo_rd_en), 32'd1);
            if (c >= 3) check_eq("t4_rd_blocked", 32'(fifo_rd_en), 32'd0);
        end
        check_eq("t4_held", 32'(data_out), 32'h10);
        drain("t4_drain", 60);
        check_eq("t4_accepts", 32'(n_acc - acc0), 32'd12);

        // Flush with byte_cnt = 2 while a read is in flight
        fifo_q.push_back(32'hA3A2A1A0);
        for (int c = 0; c < 4; c++) tick(1'b1, 1'b0);
        fifo_q.push_back(32'hB3B2B1B0);
        tick(1'b0, 1'b0);
        check_eq("t5_rd_before_flush", 32'(fifo_rd_en), 32'd1);
        check_eq("t5_byte2", 32'(data_out), 32'hA2);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        check_eq("t5_valid_after_flush", 32'(valid_out), 32'd0);
        fifo_q.push_back(32'hC3C2C1C0);
        wait_valid("t5_wait", 20);
        check_eq("t5_restart_byte0", 32'(data_out), 32'hC0);
        drain("t5_drain", 40);

        // Reset mid-word at byte_cnt = 1
        fifo_q.push_back(32'hD3D2D1D0);
        for (int c = 0; c < 3; c++) tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        check_eq("t6_byte1", 32'(data_out), 32'hD1);
        fifo_q.push_back(32'hE3E2E1E0);
        apply_reset();
        wait_valid("t6_wait", 20);
        check_eq("t6_restart_byte0", 32'(data_out), 32'hE0);
        drain("t6_drain", 40);

        // Random backpressure over several words
        acc0 = n_acc;
        for (int i = 0; i < 6; i++) fifo_q.push_back(DATA_LEN'($urandom));
        begin
            int k = 0;
            while ((sb_q.size() != 0 || fifo_q.size() != 0 || valid_out || rd_prev) && k < 600) begin
                tick(1'($urandom_range(0, 1)), 1'b0);
                k++;
            end
        end
        check_eq("t7_drain", 32'(sb_q.size()), 32'd0);
        check_eq("t7_accepts", 32'(n_acc - acc0), 32'd24);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #(T_CLK * 20000);
        $display("FAIL watchdog: simulation did not complete at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
